// File: rtl/axis_preload_pack_fifo.sv
// ---------------------------------------------------------------------------
// axis_preload_pack_fifo
//   Packs AXI-Stream beats of ELEMS_PER_BEAT small elements into full MAC rows
//   (MAC_NUM elements each) and queues complete rows in a FIFO_DEPTH-slot
//   buffer. The head row is exposed in parallel on row_out.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   s_axis_tdata/tvalid/  AXIS slave; element k at [k*ELEM_WIDTH +: ELEM_WIDTH]
//   tready/tlast          tlast forces the current row to commit
//   input_channel_size    active elements per row (0 -> one beat, clamped)
//   axis_clear            synchronous flush of pointers and counters
//   row_out/row_valid/    head row, present flag, consumer pop
//   row_ready
//   fifo_cnt/empty/full   committed row count and flags
//   row_partial           a row is currently under assembly
// ---------------------------------------------------------------------------
module axis_preload_pack_fifo #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int ELEM_WIDTH           = 5,
    parameter int ELEMS_PER_BEAT       = 6,
    parameter int MAC_NUM              = 256,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic [11:0]                        input_channel_size,
    input  logic                               axis_clear,
    output logic [ELEM_WIDTH*MAC_NUM-1:0]      row_out,
    output logic                               row_valid,
    input  logic                               row_ready,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_cnt,
    output logic                               fifo_empty,
    output logic                               fifo_full,
    output logic                               row_partial
);

    localparam int RW = ELEM_WIDTH * MAC_NUM;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(MAC_NUM + ELEMS_PER_BEAT);
    localparam int BW = ELEM_WIDTH * ELEMS_PER_BEAT;

    logic [RW-1:0] slot_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FW-1:0] fill_cnt_q;
    logic [CW-1:0] cnt_q;

    logic                                     accept, pop, commit;
    logic [31:0]                              eff_size;
    logic [RW-1:0]                            row_d;
    logic [ELEMS_PER_BEAT-1:0][ELEM_WIDTH-1:0] beat_elems;
    logic                                     unused_tdata;

    assign beat_elems   = s_axis_tdata[BW-1:0];
    assign unused_tdata = ^s_axis_tdata;

    assign fifo_cnt      = cnt_q;
    assign fifo_empty    = (cnt_q == '0);
    assign fifo_full     = (cnt_q == CW'(FIFO_DEPTH));
    assign row_valid     = ~fifo_empty;
    assign row_out       = slot_q[rd_ptr_q];
    assign row_partial   = (fill_cnt_q != '0);
    assign pop           = row_valid & row_ready;
    // A pop frees the head slot at the same edge, so a full FIFO can still
    // take a beat in that cycle.
    assign s_axis_tready = ~axis_clear & (~fifo_full | pop);
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Row length in elements: 0 means a single beat, anything larger than
    // the row is clamped to the row.
    always_comb begin
        if (input_channel_size == '0)
            eff_size = ELEMS_PER_BEAT;
        else if (32'(input_channel_size) > MAC_NUM)
            eff_size = MAC_NUM;
        else
            eff_size = 32'(input_channel_size);
    end

    assign commit = accept &
                    (s_axis_tlast | ((32'(fill_cnt_q) + ELEMS_PER_BEAT) >= eff_size));

    // Next contents of the slot being assembled. The first beat of a row
    // starts from zero so positions never written read back as 0; later
    // beats merge into what is already there. Positions past the row end
    // are dropped.
    always_comb begin
        row_d = (fill_cnt_q == '0) ? '0 : slot_q[wr_ptr_q];
        for (int k = 0; k < ELEMS_PER_BEAT; k++) begin
            if ((32'(fill_cnt_q) + k) < MAC_NUM)
                row_d[(32'(fill_cnt_q) + k) * ELEM_WIDTH +: ELEM_WIDTH] = beat_elems[k];
        end
    end

    // Slot storage; axis_clear leaves contents alone (accept is already
    // blocked during clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) slot_q[i] <= '0;
        end else if (accept) begin
            slot_q[wr_ptr_q] <= row_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_cnt_q <= '0;
            cnt_q      <= '0;
        end else if (axis_clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (commit) begin
                fill_cnt_q <= '0;
                wr_ptr_q   <= wr_ptr_q + PW'(1);
            end else if (accept) begin
                fill_cnt_q <= fill_cnt_q + FW'(ELEMS_PER_BEAT);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({commit, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_preload_pack_fifo.sv
module tb_axis_preload_pack_fifo;

  localparam int DW  = 32;
  localparam int EW  = 5;
  localparam int EPB = 6;
  localparam int MN  = 16;
  localparam int FD  = 4;
  localparam int RW  = EW * MN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [11:0]   input_channel_size = 12'd16;
  logic          axis_clear = 1'b0;
  logic [RW-1:0] row_out;
  logic          row_valid;
  logic          row_ready = 1'b0;
  logic [2:0]    fifo_cnt;
  logic          fifo_empty, fifo_full, row_partial;

  axis_preload_pack_fifo #(
    .C_S_AXIS_TDATA_WIDTH(DW), .ELEM_WIDTH(EW), .ELEMS_PER_BEAT(EPB),
    .MAC_NUM(MN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .input_channel_size(input_channel_size), .axis_clear(axis_clear),
    .row_out(row_out), .row_valid(row_valid), .row_ready(row_ready),
    .fifo_cnt(fifo_cnt), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .row_partial(row_partial)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] expq[$];
  int errors = 0;
  int checks = 0;

  // beat with elements k<n = base+k, rest 0
  function automatic logic [DW-1:0] mkb(input int base, input int n);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[k*EW +: EW] = EW'(base + k);
    return d;
  endfunction

  // expected row with elements i<n = base+i, rest 0
  function automatic logic [RW-1:0] mkrow(input int base, input int n);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*EW +: EW] = EW'(base + i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", RW'(acc), RW'(1));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 30 && !fifo_empty; n++) @(negedge clk);
    chk("drain", RW'(fifo_empty), RW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"},   RW'(fifo_empty),    RW'(1));
    chk({tag, "_full"},    RW'(fifo_full),     RW'(0));
    chk({tag, "_valid"},   RW'(row_valid),     RW'(0));
    chk({tag, "_partial"}, RW'(row_partial),   RW'(0));
    chk({tag, "_rowout"},  row_out,            RW'(0));
    chk({tag, "_tready"},  RW'(s_axis_tready), RW'(1));
  endtask

  initial begin
    // monitor: compare every popped head row against the scoreboard
    fork
      forever begin
        @(negedge clk);
        if (row_valid && row_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got %h want none", row_out);
          end else begin
            chk("row_order", row_out, expq.pop_front());
          end
        end
      end
    join_none

    // reset state before any clock edge
    #2;
    chk_idle("rst");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 16-element row from 3 beats, values 17/18 dropped
    row_ready = 1'b1;
    input_channel_size = 12'd16;
    expq.push_back(mkrow(1, 16));
    send(mkb(1, 6), 1'b0);
    chk("t1_partial", RW'(row_partial), RW'(1));
    send(mkb(7, 6), 1'b0);
    send(mkb(13, 6), 1'b0);
    chk("t1_cnt", RW'(fifo_cnt), RW'(1));
    chk("t1_partial0", RW'(row_partial), RW'(0));
    wait_empty();

    // size 10: commit after 2 beats, tail zero
    input_channel_size = 12'd10;
    expq.push_back(mkrow(21, 10));
    send(mkb(21, 6), 1'b0);
    send(mkb(27, 4), 1'b0);
    chk("t2_cnt", RW'(fifo_cnt), RW'(1));
    wait_empty();

    // fill all 4 slots with consumer stalled
    row_ready = 1'b0;
    input_channel_size = 12'd16;
    for (int r = 0; r < 4; r++) begin
      expq.push_back(mkrow(2 + 5*r, 16));
      send(mkb(2 + 5*r, 6), 1'b0);
      send(mkb(8 + 5*r, 6), 1'b0);
      send(mkb(14 + 5*r, 6), 1'b0);
    end
    chk("full_flag", RW'(fifo_full), RW'(1));
    chk("full_cnt", RW'(fifo_cnt), RW'(4));
    @(negedge clk);
    chk("full_tready", RW'(s_axis_tready), RW'(0));
    @(posedge clk);
    #1;
    // pop and a single-beat row commit in the same cycle
    input_channel_size = 12'd6;
    expq.push_back(mkrow(9, 6));
    s_axis_tdata  = mkb(9, 6);
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    row_ready     = 1'b1;
    @(negedge clk);
    chk("pop_tready", RW'(s_axis_tready), RW'(1));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    chk("pop_cnt_hold", RW'(fifo_cnt), RW'(4));
    wait_empty();

    // tlast on first beat of a 16-element row
    input_channel_size = 12'd16;
    expq.push_back(mkrow(5, 6));
    send(mkb(5, 6), 1'b1);
    chk("t3_cnt", RW'(fifo_cnt), RW'(1));
    chk("t3_partial", RW'(row_partial), RW'(0));
    wait_empty();

    // clear with 2 rows stored and a row under assembly
    row_ready = 1'b0;
    input_channel_size = 12'd6;
    expq.push_back(mkrow(1, 6));
    send(mkb(1, 6), 1'b0);
    expq.push_back(mkrow(7, 6));
    send(mkb(7, 6), 1'b0);
    input_channel_size = 12'd16;
    send(mkb(13, 6), 1'b0);
    chk("clr_pre_cnt", RW'(fifo_cnt), RW'(2));
    chk("clr_pre_partial", RW'(row_partial), RW'(1));
    axis_clear    = 1'b1;
    s_axis_tdata  = mkb(20, 6);
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("clr_tready", RW'(s_axis_tready), RW'(0));
    @(posedge clk);
    #1;
    axis_clear    = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("clr_cnt", RW'(fifo_cnt), RW'(0));
    chk("clr_valid", RW'(row_valid), RW'(0));
    chk("clr_partial", RW'(row_partial), RW'(0));
    expq.delete();
    row_ready = 1'b1;
    input_channel_size = 12'd6;
    expq.push_back(mkrow(25, 6));
    send(mkb(25, 6), 1'b0);
    wait_empty();

    // async reset mid-row with a committed row held
    row_ready = 1'b0;
    expq.push_back(mkrow(3, 6));
    send(mkb(3, 6), 1'b0);
    input_channel_size = 12'd16;
    send(mkb(9, 6), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("arst");
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    row_ready = 1'b1;
    input_channel_size = 12'd6;
    expq.push_back(mkrow(11, 6));
    send(mkb(11, 6), 1'b0);
    wait_empty();

    chk("queue_empty", RW'(expq.size()), RW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
